// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding, parity modes, and the parity helper.
// Both the transmitter and the matching receiver use this package.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned CLK_DIV_9600_100MHZ = 10416;
    localparam int unsigned MAX_DATA_BITS       = 9;

    // Parity bit for a word zero-extended to the widest legal frame; zero padding leaves parity unchanged.
    function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] word,
                                       input int unsigned              mode);
        return (mode == PAR_ODD) ? ~(^word) : ^word;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 while enabled and flags the last cycle of each period.
// The tick is a decode of the counter so the owning FSM can act on the same edge the period ends.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_9600_100MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_W'(CLK_DIV - 1));
    assign tick = enable && wrap;

    // Clear restarts the period so a new frame never inherits phase from the previous one.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one word per valid/ready handshake, LSB first,
// optional parity, one or two stop bits, one-cycle done pulse as the last stop bit ends.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = CLK_DIV_9600_100MHZ,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = PAR_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 TxD,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned BIT_W = 4;

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_tx_frame: CLK_DIV must be >= 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > MAX_DATA_BITS)) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    uart_state_e          state;
    uart_state_e          state_nxt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_cnt_nxt;
    logic                 par_bit;
    logic                 par_bit_nxt;
    logic                 txd_nxt;
    logic                 done_nxt;
    logic                 accept;
    logic                 tick;
    logic                 last_data;
    logic                 last_stop;

    assign tx_ready  = (state == IDLE);
    assign tx_busy   = (state != IDLE);
    assign accept    = tx_valid && tx_ready;
    assign last_data = (bit_cnt == BIT_W'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == BIT_W'(STOP_BITS - 1));

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (tx_busy),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tick && last_data) begin
                    state_nxt = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick && last_stop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word capture and per-bit bookkeeping; bit_cnt counts data bits, then stop bits.
    always_comb begin
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        par_bit_nxt = par_bit;
        if (accept) begin
            shift_nxt   = tx_data;
            bit_cnt_nxt = '0;
            par_bit_nxt = parity_of(MAX_DATA_BITS'(tx_data), PARITY);
        end else if (tick) begin
            case (state)
                DATA: begin
                    shift_nxt   = shift >> 1;
                    bit_cnt_nxt = last_data ? '0 : bit_cnt + BIT_W'(1);
                end
                STOP: begin
                    bit_cnt_nxt = last_stop ? '0 : bit_cnt + BIT_W'(1);
                end
                default: begin
                    bit_cnt_nxt = bit_cnt;
                end
            endcase
        end
    end

    // Line level for the upcoming cycle, so TxD changes on the same edge as the state.
    always_comb begin
        txd_nxt  = 1'b1;
        done_nxt = 1'b0;
        case (state_nxt)
            START:            txd_nxt = 1'b0;
            DATA:             txd_nxt = shift_nxt[0];
            uart_pkg::PARITY: txd_nxt = par_bit_nxt;
            default:          txd_nxt = 1'b1;
        endcase
        if ((state == STOP) && (state_nxt == IDLE)) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            TxD     <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            par_bit <= par_bit_nxt;
            TxD     <= txd_nxt;
            tx_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: several parameter sets side by side, each frame
// checked cycle by cycle against a queue of expected words.
`timescale 1ns/1ps
module tb_uart_tx_frame;

    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid [NI];
    logic [8:0]  data  [NI];
    logic        ready [NI];
    logic        txd   [NI];
    logic        busy  [NI];
    logic        done  [NI];
    logic [8:0]  exp_q [NI][$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
        .tx_ready(ready[0]), .TxD(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .tx_valid(valid[1]), .tx_data(data[1][7:0]),
        .tx_ready(ready[1]), .TxD(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .tx_valid(valid[2]), .tx_data(data[2][7:0]),
        .tx_ready(ready[2]), .TxD(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .reset(reset), .tx_valid(valid[3]), .tx_data(data[3][6:0]),
        .tx_ready(ready[3]), .TxD(txd[3]), .tx_busy(busy[3]), .tx_done(done[3]));
    uart_tx_frame u_dflt (
        .clk(clk), .reset(reset), .tx_valid(valid[4]), .tx_data(data[4][7:0]),
        .tx_ready(ready[4]), .TxD(txd[4]), .tx_busy(busy[4]), .tx_done(done[4]));

    function automatic int cd_of(input int i);
        return (i == 4) ? 10416 : 4;
    endfunction
    function automatic int db_of(input int i);
        return (i == 3) ? 7 : 8;
    endfunction
    function automatic int par_of(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int sb_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    // Expected line bits, index 0 = start bit; returns the number of bits in the frame.
    function automatic int build_frame(input int i, input logic [8:0] w, output logic [12:0] bits);
        int n    = 0;
        int ones = 0;
        bits = '1;
        bits[n] = 1'b0;
        n++;
        for (int b = 0; b < db_of(i); b++) begin
            bits[n] = w[b];
            ones += int'(w[b]);
            n++;
        end
        if (par_of(i) == 2) begin
            bits[n] = 1'(ones % 2);
            n++;
        end else if (par_of(i) == 1) begin
            bits[n] = 1'((ones + 1) % 2);
            n++;
        end
        return n + sb_of(i);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Call at a negedge; returns just after the acceptance edge.
    task automatic wait_accept(input int i, input string tag, output bit ok, output int unsigned at);
        ok = 1'b0;
        at = 0;
        for (int t = 0; t < 200; t++) begin
            if (valid[i] && ready[i]) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, "_accepted"}, 32'(ok), 32'd1);
    endtask

    task automatic check_frame(input int i, input string tag, input bit drop, output int unsigned at);
        bit          ok;
        logic [8:0]  w;
        logic [12:0] ev;
        logic [12:0] ov;
        int          n;
        int          cd;
        int          glitches = 0;
        int          dones = 0;
        int          idle = 0;
        wait_accept(i, tag, ok, at);
        if (!ok) return;
        if (drop) valid[i] = 1'b0;
        w  = exp_q[i].pop_front();
        n  = build_frame(i, w, ev);
        cd = cd_of(i);
        ov = '1;
        for (int k = 0; k < n * cd; k++) begin
            @(negedge clk);
            if (txd[i] !== ev[k / cd]) glitches++;
            if ((k % cd) == (cd / 2)) ov[k / cd] = txd[i];
            if (done[i] !== 1'b0) dones++;
            if (busy[i] !== 1'b1) idle++;
        end
        @(negedge clk);
        check_eq({tag, "_bits"}, 32'(ov), 32'(ev));
        check_eq({tag, "_glitch_cycles"}, 32'(glitches), 32'd0);
        check_eq({tag, "_early_done"}, 32'(dones), 32'd0);
        check_eq({tag, "_busy_drop"}, 32'(idle), 32'd0);
        check_eq({tag, "_done_end"}, 32'(done[i]), 32'd1);
        check_eq({tag, "_ready_end"}, 32'(ready[i]), 32'd1);
        check_eq({tag, "_busy_end"}, 32'(busy[i]), 32'd0);
        check_eq({tag, "_txd_end"}, 32'(txd[i]), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int unsigned a1;
        int unsigned a2;
        int          width;
        int          dcount;

        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            valid[i] = 1'b0;
            data[i]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("rst_txd_%0d", i), 32'(txd[i]), 32'd1);
            check_eq($sformatf("rst_ready_%0d", i), 32'(ready[i]), 32'd1);
            check_eq($sformatf("rst_busy_%0d", i), 32'(busy[i]), 32'd0);
            check_eq($sformatf("rst_done_%0d", i), 32'(done[i]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // 8N1 basic frame
        exp_q[0].push_back(9'h0A5);
        valid[0] = 1'b1;
        data[0]  = 9'h0A5;
        check_frame(0, "8n1_a5", 1'b1, a1);

        // parity variants
        exp_q[1].push_back(9'h007);
        valid[1] = 1'b1;
        data[1]  = 9'h007;
        check_frame(1, "even_07", 1'b1, a1);
        exp_q[2].push_back(9'h007);
        valid[2] = 1'b1;
        data[2]  = 9'h007;
        check_frame(2, "odd_07", 1'b1, a1);
        exp_q[1].push_back(9'h000);
        valid[1] = 1'b1;
        data[1]  = 9'h000;
        check_frame(1, "even_00", 1'b1, a1);

        // 7 data bits, two stop bits
        exp_q[3].push_back(9'h07F);
        valid[3] = 1'b1;
        data[3]  = 9'h07F;
        check_frame(3, "7n2_7f", 1'b1, a1);

        // back-to-back with tx_data changing mid-frame
        exp_q[0].push_back(9'h055);
        exp_q[0].push_back(9'h0AA);
        valid[0] = 1'b1;
        data[0]  = 9'h055;
        fork
            begin
                repeat (10) @(negedge clk);
                data[0] = 9'h0AA;
                repeat (45) @(negedge clk);
                valid[0] = 1'b0;
            end
            begin
                check_frame(0, "b2b_55", 1'b0, a1);
                check_frame(0, "b2b_aa", 1'b0, a2);
                check_eq("b2b_gap", 32'(a2 - a1), 32'd41);
            end
        join
        repeat (5) @(negedge clk);

        // reset in the middle of data bit 3 aborts the frame
        valid[0] = 1'b1;
        data[0]  = 9'h000;
        wait_accept(0, "abort", ok, a1);
        valid[0] = 1'b0;
        repeat (18) @(negedge clk);
        check_eq("abort_pre_txd", 32'(txd[0]), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_txd", 32'(txd[0]), 32'd1);
        check_eq("abort_busy", 32'(busy[0]), 32'd0);
        check_eq("abort_ready", 32'(ready[0]), 32'd1);
        dcount = 0;
        for (int k = 0; k < 60; k++) begin
            if (done[0] !== 1'b0) dcount++;
            @(negedge clk);
        end
        check_eq("abort_no_done", 32'(dcount), 32'd0);
        exp_q[0].push_back(9'h03C);
        valid[0] = 1'b1;
        data[0]  = 9'h03C;
        check_frame(0, "post_abort_3c", 1'b1, a1);

        // default divisor: start-bit width, valid while busy ignored
        valid[4] = 1'b1;
        data[4]  = 9'h0FF;
        wait_accept(4, "dflt", ok, a1);
        valid[4] = 1'b0;
        width = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (k == 100) begin
                check_eq("dflt_busy_ready", 32'(ready[4]), 32'd0);
                valid[4] = 1'b1;
                data[4]  = 9'h000;
            end
            if (k == 101) begin
                valid[4] = 1'b0;
                check_eq("dflt_busy_ready2", 32'(ready[4]), 32'd0);
            end
            if (txd[4] !== 1'b0) break;
            width++;
        end
        check_eq("dflt_start_width", 32'(width), 32'd10416);
        check_eq("dflt_busy_after_start", 32'(busy[4]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("dflt_abort_txd", 32'(txd[4]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
